// File: rtl/oka_mul_arbiter_193bit.sv
// Two-requester arbiter in front of an external combinational OKA multiplier.
// It holds the accepted operands for MUL_WAIT cycles, then registers the product for the consumer.
module oka_mul_arbiter_193bit #(
  parameter int WIDTH    = 193,
  parameter int MUL_WAIT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-2:0] mul_y,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-2:0] res_y,
  output logic               res_id,
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t               state_q, state_d;
  logic                 prio_q, prio_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [WIDTH-1:0]     mul_a_q, mul_a_d;
  logic [WIDTH-1:0]     mul_b_q, mul_b_d;
  logic [2*WIDTH-2:0]   res_y_q, res_y_d;
  logic                 res_id_q, res_id_d;
  logic                 id_lat_q, id_lat_d;
  logic                 grant1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      prio_q   <= 1'b0;
      cnt_q    <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      res_y_q  <= '0;
      res_id_q <= 1'b0;
      id_lat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      cnt_q    <= cnt_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      res_y_q  <= res_y_d;
      res_id_q <= res_id_d;
      id_lat_q <= id_lat_d;
    end
  end

  // Requester 1 wins when it is the only one valid, or on a tie while prio points at it.
  assign grant1 = req1_valid && (!req0_valid || prio_q);

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    cnt_d      = cnt_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    res_y_d    = res_y_q;
    res_id_d   = res_id_q;
    id_lat_d   = id_lat_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rst) begin
          req0_ready = req0_valid && !grant1;
          req1_ready = grant1;
        end
        if (req0_ready || req1_ready) begin
          mul_a_d  = grant1 ? req1_a : req0_a;
          mul_b_d  = grant1 ? req1_b : req0_b;
          id_lat_d = grant1;
          prio_d   = !grant1;
          cnt_d    = '0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(MUL_WAIT - 1)) begin
          res_y_d  = mul_y;
          res_id_d = id_lat_q;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign res_y     = res_y_q;
  assign res_id    = res_id_q;
  assign res_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/oka_mul_arbiter_193bit.md
OKA_MUL_ARBITER_193BIT -- requirements
Module: oka_mul_arbiter_193bit

Interface
REQ-001 Parameter WIDTH, default 193: operand width in bits; product width is 2*WIDTH-1.
REQ-002 Parameter MUL_WAIT, default 2: cycles operands are held on the multiplier before the product is sampled; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 has an operand pair.
REQ-006 req0_ready  output  1  requester 0 pair accepted this cycle when high with req0_valid.
REQ-007 req0_a, req0_b  input  WIDTH each  requester 0 operands.
REQ-008 req1_valid, req1_ready, req1_a, req1_b  as REQ-005..007, for requester 1.
REQ-009 mul_a, mul_b  output  WIDTH each  registered operands driven to the external combinational OKA multiplier.
REQ-010 mul_y  input  2*WIDTH-1  product returned by the external multiplier.
REQ-011 res_valid  output  1  result available.
REQ-012 res_ready  input  1  consumer accepts result.
REQ-013 res_y  output  2*WIDTH-1  registered product.
REQ-014 res_id  output  1  index of requester owning res_y.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states IDLE, WAIT, DONE; one operation in flight at a time.
REQ-017 IDLE: reqN_ready is combinational, high only for the arbitration winner and only while its reqN_valid is high; the loser's ready is 0.
REQ-018 Arbitration: if only one valid, it wins; if both valid, the requester equal to priority pointer prio wins.
REQ-019 On an IDLE-state accepting edge: mul_a/mul_b <= winner's operands, res_id_next <= winner index, prio <= ~winner, wait counter <= 0, state -> WAIT.
REQ-020 WAIT: counter increments each edge; on the edge where counter == MUL_WAIT-1, res_y <= mul_y, res_id <= latched index, state -> DONE.
REQ-021 Latency: res_valid rises exactly MUL_WAIT edges after the accepting edge (MUL_WAIT=2: accept edge E0, res_valid high after E2).
REQ-022 DONE: res_valid=1; res_y/res_id stable; on edge with res_ready=1 state -> IDLE; res_ready low holds DONE indefinitely.
REQ-023 res_valid is 0 in IDLE and WAIT; reqN_ready is 0 in WAIT and DONE.
REQ-024 mul_a/mul_b change only on an accepting edge; they are stable throughout WAIT and DONE.
REQ-025 No bypass: a new request is never accepted in the same cycle a result is consumed; minimum spacing between accepts is MUL_WAIT+2 cycles.
REQ-026 mul_y is sampled only on the REQ-020 edge; its value in other cycles is ignored.
REQ-027 prio changes only on accepting edges.

Reset
REQ-028 rst high on an edge: state -> IDLE, prio <= 0, counter <= 0, mul_a/mul_b <= 0, res_y <= 0, res_id <= 0; hence res_valid=0, busy=0.
REQ-029 Reset mid-operation (WAIT or DONE) discards the in-flight operation with no result delivered; reqN_ready is 0 during any cycle rst is high.
REQ-030 First accept after reset with both requesters valid grants requester 0.

Verification (bench stub: mul_y = carry-less product of mul_a, mul_b; chosen values give equal integer and carry-less results)
REQ-031 Single op: req0 a=5 b=3, MUL_WAIT=2, res_ready=1 -> req0_ready high in IDLE, res_valid after 2nd edge post-accept, res_y=15, res_id=0, busy back to 0 one edge later.
REQ-032 Contention: both valid from reset (req0 a=5 b=3, req1 a=2 b=7) -> req0 served first (res_y=15, res_id=0), then req1 (res_y=14, res_id=1); next tie goes to req0 again.
REQ-033 Backpressure: res_ready=0 for 10 cycles in DONE -> res_valid, res_y, res_id, mul_a, mul_b constant, both ready low; release -> IDLE after one edge.
REQ-034 Stability: toggle req0_a/req0_b and mul_y glitch values during WAIT except on sample edge -> res_y equals product of originally accepted operands.
REQ-035 Reset mid-op: assert rst during WAIT -> after edge res_valid=0, busy=0, mul_a=0, res_y=0; no stale result appears afterward.
REQ-036 MUL_WAIT=1 and MUL_WAIT=15 builds -> res_valid rises exactly 1 and 15 edges after accept respectively.
